booth_mul_arbiter: RTL and testbench
====================================

Name: booth_mul_arbiter

Overview:
- Shares one sequential Booth multiplier (Start/Ready/A/x/product interface, W-bit operands, 2W-bit product) among N requesters.
- Performs round-robin arbitration and latches the winner's operands.
- Sequences the multiplier's Start/Ready handshake, short-circuits zero-operand requests, guards against a hung multiplier with a timeout, and returns the tagged result.
- Sits between client blocks and the multiplier instance in the arithmetic subsystem.

Parameters:
- N, 4, number of requesters (2..8)
- W, 4, operand width; must match the multiplier's L_word
- TIMEOUT, 64, max cycles spent in WAIT before abort (>=2)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  N  request per client; held until its gnt pulse
- a_in  in  N*W  multiplicand per client; slice i = [i*W +: W]
- x_in  in  N*W  multiplier per client; same slicing
- gnt  out  N  one-hot, one-cycle pulse: operands of client i captured
- done  out  1  one-cycle pulse: result/done_id valid
- done_id  out  clog2(N) (min 1)  client index of the completed job
- result  out  2W  product; registered, held until next done
- timeout_err  out  1  sticky; set on timeout, cleared only by reset
- busy  out  1  high in every state except IDLE
- mul_A  out  W  operand A to multiplier (latched register)
- mul_x  out  W  operand x to multiplier (latched register)
- mul_start  out  1  Start to multiplier, one-cycle pulse
- mul_ready  in  1  Ready from multiplier (high when idle)
- mul_product  in  2W  product from multiplier

Behaviour:
- Reset values:
  - All outputs 0, state=IDLE, round-robin pointer=0, wait counter=0.
  - Reset mid-operation aborts the job: no done is issued, and the client must re-request.
- States: IDLE, ISSUE, LAUNCH, WAIT, DONE.
- IDLE:
  - Arbitration happens only when any req=1 and mul_ready=1.
  - Winner = first asserted req scanning from pointer upward with wrap-around.
  - In the winner cycle: latch a_in/x_in slices into mul_A/mul_x and the index into the id register; gnt[winner]=1 for that cycle; pointer <= winner+1 (mod N).
  - If the latched operands have A==0 or x==0: go to DONE with result 0. The multiplier is not started.
  - Otherwise go to ISSUE.
- ISSUE: mul_start=1 for exactly one cycle -> LAUNCH.
- LAUNCH: mul_ready is ignored for this cycle, because the multiplier leaves idle on this edge -> WAIT.
- WAIT:
  - If mul_ready=1: result <= mul_product -> DONE.
  - Otherwise increment the counter.
  - When the counter reaches TIMEOUT-1 with mul_ready still 0: set timeout_err, result <= all-ones -> DONE.
- DONE:
  - done=1 and done_id=latched id for one cycle; counter cleared -> IDLE.
- Other rules:
  - mul_A/mul_x hold constant from capture until the next capture; they are never changed while busy.
  - Requests arriving while busy wait; req sampled outside IDLE has no effect.
  - A client whose req drops before it is granted is simply skipped.
  - Minimum turnaround: back-to-back jobs need one IDLE cycle between DONE and the next gnt.
  - Zero-operand job: gnt to done is exactly 2 cycles (IDLE -> DONE).
  - Nonzero job: gnt to done = 4 + the multiplier's busy cycles.
  - A requester whose req is still high in the cycle after its gnt is treated as a new request.
  - Unused state encodings -> IDLE.

Test Plan:
- W=4, N=4. Bench multiplier model: Ready drops the cycle after Start, product = signed A*x, Ready returns after 5 cycles. Single req[2], a=3, x=5 -> gnt=4'b0100 for 1 cycle, mul_start pulse 1 cycle later; done with done_id=2, result=8'h0F.
- req=4'b1111 held continuously, pointer=0 -> grants in order 0,1,2,3,0. Each gnt occurs only after the previous done plus 1 IDLE cycle.
- req[1], a=4'hD (-3), x=5 -> result=8'hF1. mul_A=4'hD is stable for the whole job.
- req[3], a=0, x=7 -> mul_start never asserts; done 2 cycles after gnt, result=0, done_id=3.
- Model holds Ready low forever, TIMEOUT=64 -> done 64 cycles after entering WAIT, result=8'hFF, timeout_err=1 and sticky. A subsequent normal job still completes.
- Assert reset while in WAIT -> all outputs 0 immediately, state IDLE, no done. A fresh req[0] after reset is granted normally.

Source files
------------

// File: rtl/booth_mul_arbiter_if.sv
// Bundle between the multiplier arbiter, its client blocks and the shared
// Booth multiplier. The arbiter uses the slave modport; the surrounding
// environment (clients plus multiplier instance) uses the master modport.
//
// Signals:
//   req/a_in/x_in         client requests and per-client operand slices
//   gnt/done/done_id/...  grant pulse, completion pulse, tag and product
//   mul_*                 Start/Ready/A/x/product link to the multiplier
interface booth_mul_arbiter_if #(
  parameter int N = 4,
  parameter int W = 4
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]     req;
  logic [N*W-1:0]   a_in;
  logic [N*W-1:0]   x_in;
  logic [N-1:0]     gnt;
  logic             done;
  logic [IDW-1:0]   done_id;
  logic [2*W-1:0]   result;
  logic             timeout_err;
  logic             busy;
  logic [W-1:0]     mul_A;
  logic [W-1:0]     mul_x;
  logic             mul_start;
  logic             mul_ready;
  logic [2*W-1:0]   mul_product;

  modport slave (
    input  req, a_in, x_in, mul_ready, mul_product,
    output gnt, done, done_id, result, timeout_err, busy,
           mul_A, mul_x, mul_start
  );

  modport master (
    output req, a_in, x_in, mul_ready, mul_product,
    input  gnt, done, done_id, result, timeout_err, busy,
           mul_A, mul_x, mul_start
  );
endinterface

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter sharing one sequential Booth multiplier among N clients.
// Latency: gnt->done is 2 cycles for a zero operand, 4 + multiplier busy cycles otherwise.
// Backpressure: clients hold req until gnt; no arbitration while busy or while mul_ready=0.
//
// Ports:
//   clk, reset   rising-edge clock, asynchronous active-high reset
//   bus (slave)  req/a_in/x_in in, gnt/done/done_id/result/timeout_err/busy out,
//                mul_A/mul_x/mul_start out, mul_ready/mul_product in
module booth_mul_arbiter #(
  parameter int N       = 4,
  parameter int W       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  booth_mul_arbiter_if.slave bus
);

  localparam int IDW = (N > 1) ? $clog2(N) : 1;
  localparam int IW1 = IDW + 1;
  localparam int CW  = $clog2(TIMEOUT) + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]     state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] id_q;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   a_q;
  logic [W-1:0]   x_q;
  logic [2*W-1:0] res_q;
  logic [2*W-1:0] result_q;
  logic           done_q;
  logic [IDW-1:0] done_id_q;
  logic           to_err_q;

  logic           win_vld;
  logic [IDW-1:0] win_idx;
  logic [IW1-1:0] idx;
  logic           grant;
  logic [N-1:0]   gnt_c;
  logic [W-1:0]   a_sel;
  logic [W-1:0]   x_sel;

  // First asserted request at or above the pointer, wrapping around.
  // ptr < N and k < N, so one conditional subtract is enough for the wrap.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr} + IW1'(k);
      if (idx >= IW1'(N)) begin
        idx = idx - IW1'(N);
      end
      if (!win_vld && bus.req[idx[IDW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = idx[IDW-1:0];
      end
    end
  end

  // Grant is only issued from IDLE with the multiplier idle; gated by reset
  // so no pulse can leak out while the block is being held in reset.
  assign grant = (state == S_IDLE) && bus.mul_ready && win_vld && !reset;

  always_comb begin
    gnt_c = '0;
    if (grant) begin
      gnt_c[win_idx] = 1'b1;
    end
  end

  assign a_sel = bus.a_in[int'(win_idx)*W +: W];
  assign x_sel = bus.x_in[int'(win_idx)*W +: W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      ptr       <= '0;
      id_q      <= '0;
      cnt       <= '0;
      a_q       <= '0;
      x_q       <= '0;
      res_q     <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      to_err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant) begin
            a_q  <= a_sel;
            x_q  <= x_sel;
            id_q <= win_idx;
            ptr  <= (win_idx == IDW'(N - 1)) ? '0 : win_idx + IDW'(1);
            // A zero operand makes the product trivially zero; skip the multiplier.
            if (a_sel == '0 || x_sel == '0) begin
              res_q <= '0;
              state <= S_DONE;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          state <= S_LAUNCH;
        end
        S_LAUNCH: begin
          // Ready may still read high here while the multiplier is leaving idle.
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.mul_ready) begin
            res_q <= bus.mul_product;
            state <= S_DONE;
          end else if (cnt == CW'(TIMEOUT - 2)) begin
            // Counter would reach TIMEOUT-1 on this edge: give up on the job.
            to_err_q <= 1'b1;
            res_q    <= '1;
            state    <= S_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: begin
          done_q    <= 1'b1;
          done_id_q <= id_q;
          result_q  <= res_q;
          cnt       <= '0;
          state     <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt         = gnt_c;
  assign bus.done        = done_q;
  assign bus.done_id     = done_id_q;
  assign bus.result      = result_q;
  assign bus.timeout_err = to_err_q;
  assign bus.busy        = (state != S_IDLE);
  assign bus.mul_A       = a_q;
  assign bus.mul_x       = x_q;
  assign bus.mul_start   = (state == S_ISSUE);

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Bench for booth_mul_arbiter (N=4, W=4, TIMEOUT=64) with a behavioural
// sequential multiplier: Ready drops the cycle after Start, returns 5 cycles
// later with the signed product; a hang flag keeps Ready low.
module tb_booth_mul_arbiter;
  localparam int N  = 4;
  localparam int W  = 4;
  localparam int TO = 64;

  typedef struct {
    int         c;
    logic [3:0] a;
    logic [3:0] x;
    logic [7:0] res;
    int         lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  bit   hang  = 1'b0;
  int   mcnt  = 0;

  vec_t       tbl [8];
  int         gc [5];
  logic [3:0] gv [5];
  logic [1:0] di [5];
  logic [7:0] dr [5];

  booth_mul_arbiter_if #(.N(N), .W(W)) bus ();

  booth_mul_arbiter #(.N(N), .W(W), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.mul_ready   <= 1'b1;
      bus.mul_product <= '0;
      mcnt            <= 0;
    end else if (bus.mul_start) begin
      bus.mul_ready   <= 1'b0;
      bus.mul_product <= {{4{bus.mul_A[3]}}, bus.mul_A} * {{4{bus.mul_x[3]}}, bus.mul_x};
      mcnt            <= 5;
    end else if (!bus.mul_ready && !hang) begin
      if (mcnt <= 1) bus.mul_ready <= 1'b1;
      mcnt <= mcnt - 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.gnt, bus.done, bus.done_id, bus.result, bus.timeout_err,
                bus.busy, bus.mul_A, bus.mul_x, bus.mul_start});
  endfunction

  task automatic run_job(input int c, input logic [3:0] a, input logic [3:0] x,
                         input logic [7:0] res, input int lat, input string nm);
    logic [15:0] av;
    logic [15:0] xv;
    int g, st, dk, starts;
    bit got, stable;
    logic [3:0] gnt_after;
    av = 16'h9A7B;
    xv = 16'h6C5E;
    av[c*4 +: 4] = a;
    xv[c*4 +: 4] = x;
    @(posedge clk); #1;
    bus.a_in = av;
    bus.x_in = xv;
    bus.req  = 4'(1 << c);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.gnt != '0) got = 1'b1;
    end
    chk({nm, " gnt"}, 32'(bus.gnt), 32'(1 << c));
    g = cyc;
    @(posedge clk); #1;
    bus.req = '0;
    st = -1; dk = -1; starts = 0; stable = 1'b1; gnt_after = 4'hF;
    for (int i = 0; i < 100 && dk < 0; i++) begin
      @(negedge clk);
      if (i == 0) gnt_after = bus.gnt;
      if (bus.mul_start) begin
        starts++;
        if (st < 0) st = cyc - g;
      end
      if (bus.busy && (bus.mul_A !== a || bus.mul_x !== x)) stable = 1'b0;
      if (bus.done) dk = cyc - g;
    end
    chk({nm, " gnt_pulse"}, 32'(gnt_after), 32'd0);
    chk({nm, " latency"}, 32'(dk), 32'(lat));
    chk({nm, " done_id"}, 32'(bus.done_id), 32'(c));
    chk({nm, " result"}, 32'(bus.result), 32'(res));
    chk({nm, " starts"}, 32'(starts), (lat == 2) ? 32'd0 : 32'd1);
    chk({nm, " start_at"}, 32'(st), (lat == 2) ? 32'hFFFF_FFFF : 32'd1);
    chk({nm, " operands_stable"}, 32'(stable), 32'd1);
    @(negedge clk);
    chk({nm, " done_pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int ng, nd, ndone;
    bit got;
    logic pre_busy;

    // a, x signed 4-bit; products worked by hand
    tbl[0] = '{2, 4'h3, 4'h5, 8'h0F, 9};  //  3 *  5 =  15
    tbl[1] = '{1, 4'hD, 4'h5, 8'hF1, 9};  // -3 *  5 = -15
    tbl[2] = '{3, 4'h0, 4'h7, 8'h00, 2};  // zero A
    tbl[3] = '{0, 4'h7, 4'h7, 8'h31, 9};  //  7 *  7 =  49
    tbl[4] = '{2, 4'h8, 4'h8, 8'h40, 9};  // -8 * -8 =  64
    tbl[5] = '{1, 4'hF, 4'h0, 8'h00, 2};  // zero x
    tbl[6] = '{0, 4'h7, 4'h8, 8'hC8, 9};  //  7 * -8 = -56
    tbl[7] = '{3, 4'hF, 4'hF, 8'h01, 9};  // -1 * -1 =   1

    reset    = 1'b1;
    bus.req  = '0;
    bus.a_in = '0;
    bus.x_in = '0;

    repeat (3) @(negedge clk);
    chk("reset outputs", outs(), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("idle outputs", outs(), 32'd0);

    // Round robin from pointer 0 with all requests held
    @(posedge clk); #1;
    bus.a_in = 16'h4321;
    bus.x_in = 16'h2222;
    bus.req  = 4'hF;
    ng = 0; nd = 0;
    for (int i = 0; i < 200 && nd < 5; i++) begin
      @(negedge clk);
      if (bus.done && nd < 5) begin
        di[nd] = bus.done_id;
        dr[nd] = bus.result;
        nd++;
      end
      if (bus.gnt != '0 && ng < 5) begin
        gv[ng] = bus.gnt;
        gc[ng] = cyc;
        ng++;
        if (ng == 5) begin
          @(posedge clk); #1;
          bus.req = '0;
        end
      end
    end
    chk("rr gnt count", 32'(ng), 32'd5);
    chk("rr done count", 32'(nd), 32'd5);
    for (int j = 0; j < ng; j++)
      chk($sformatf("rr gnt%0d", j), 32'(gv[j]), 32'(1 << (j % 4)));
    for (int j = 0; j < nd; j++) begin
      chk($sformatf("rr id%0d", j), 32'(di[j]), 32'(j % 4));
      chk($sformatf("rr res%0d", j), 32'(dr[j]), 32'(2 * (j % 4 + 1)));
    end
    for (int j = 1; j < ng; j++)
      chk($sformatf("rr gap%0d", j), 32'(gc[j] - gc[j-1]), 32'd9);

    // Directed single-client vectors
    for (int i = 0; i < 8; i++)
      run_job(tbl[i].c, tbl[i].a, tbl[i].x, tbl[i].res, tbl[i].lat, $sformatf("vec%0d", i));

    // Hung multiplier: WAIT entered 3 cycles after gnt, done 64 cycles later
    chk("timeout_err clear", 32'(bus.timeout_err), 32'd0);
    hang = 1'b1;
    run_job(0, 4'h2, 4'h3, 8'hFF, 67, "timeout");
    hang = 1'b0;
    chk("timeout_err set", 32'(bus.timeout_err), 32'd1);
    run_job(1, 4'h2, 4'h3, 8'h06, 9, "after_timeout");
    chk("timeout_err sticky", 32'(bus.timeout_err), 32'd1);

    // Reset while the multiplier is busy
    @(posedge clk); #1;
    bus.a_in = 16'h0300;
    bus.x_in = 16'h0500;
    bus.req  = 4'b0100;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.gnt != '0) got = 1'b1;
    end
    chk("mid gnt", 32'(bus.gnt), 32'h4);
    @(posedge clk); #1;
    bus.req = '0;
    repeat (5) @(posedge clk);
    #1;
    pre_busy = bus.busy;
    chk("pre-reset busy", 32'(pre_busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid reset outputs", outs(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("no done after reset", 32'(ndone), 32'd0);
    run_job(0, 4'h5, 4'h3, 8'h0F, 9, "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
